// File: rtl/dmem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_arbiter_pkg
//  Brief    : Shared widths and arbiter state encoding for the dmem arbiter.
//  Revision : 1.0  initial release
// ============================================================================
package dmem_arbiter_pkg;

  localparam int DMEM_ADDR_W = 12;
  localparam int DMEM_DATA_W = 32;

  // IDLE: no owner; OWNk: port k holds a burst lock.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } arb_state_e;

endpackage
`default_nettype wire

// File: rtl/dmem_arbiter_rr_pick2.sv
`default_nettype none
// ============================================================================
//  Module   : rr_pick2
//  Brief    : Two-way round-robin pick. Single requester wins outright;
//             on contention the port named by ptr wins. Output is one-hot.
//  Revision : 1.0  initial release
// ============================================================================
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] pick
);

  // Resolve the request pair into a one-hot winner.
  always_comb begin
    pick = 2'b00;
    case (req)
      2'b01:   pick = 2'b01;
      2'b10:   pick = 2'b10;
      2'b11:   pick = ptr ? 2'b10 : 2'b01;
      default: pick = 2'b00;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_arbiter
//  Brief    : Shares the single-port dmem between the load/store unit (port 0)
//             and a secondary master (port 1). Round-robin with burst lock.
//             dmem is clocked on the falling edge, so a granted access
//             completes inside the grant cycle and load data is registered
//             on the following rising edge.
//  Revision : 1.0  initial release
// ============================================================================
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W = DMEM_ADDR_W,
  parameter int DATA_W = DMEM_DATA_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [1:0]        req,
  input  logic [1:0]        we,
  input  logic [1:0]        lock,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic [1:0]        gnt,
  output logic [1:0]        rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_wren,
  input  logic [DATA_W-1:0] mem_q
);

  arb_state_e        state;
  arb_state_e        state_next;
  logic              rr_ptr;
  logic [1:0]        pick;
  logic [1:0]        load_gnt;
  logic [1:0]        rvalid_q;
  logic [DATA_W-1:0] rdata_q;

  rr_pick2 u_pick (
    .req  (req),
    .ptr  (rr_ptr),
    .pick (pick)
  );

  // Grant and next-state: a locked owner excludes the other port; otherwise
  // the round-robin pick decides. Nothing is granted while reset is high.
  always_comb begin
    gnt        = 2'b00;
    state_next = state;
    if (!reset) begin
      case (state)
        ST_OWN0: begin
          gnt = {1'b0, req[0]};
          if (!(req[0] && lock[0])) state_next = ST_IDLE;
        end
        ST_OWN1: begin
          gnt = {req[1], 1'b0};
          if (!(req[1] && lock[1])) state_next = ST_IDLE;
        end
        default: begin
          gnt = pick;
          if (pick[0] && lock[0])      state_next = ST_OWN0;
          else if (pick[1] && lock[1]) state_next = ST_OWN1;
          else                         state_next = ST_IDLE;
        end
      endcase
    end
  end

  // Route the granted port onto the dmem bus; idle bus is driven to zero.
  always_comb begin
    mem_address = '0;
    mem_data    = '0;
    mem_wren    = 1'b0;
    if (gnt[0]) begin
      mem_address = addr0;
      mem_data    = wdata0;
      mem_wren    = we[0];
    end else if (gnt[1]) begin
      mem_address = addr1;
      mem_data    = wdata1;
      mem_wren    = we[1];
    end
  end

  assign load_gnt = gnt & ~we;

  // State, fairness pointer and one-cycle load response pipeline.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= ST_IDLE;
      rr_ptr   <= 1'b0;
      rvalid_q <= 2'b00;
      rdata_q  <= '0;
    end else begin
      state    <= state_next;
      if (gnt[0])      rr_ptr <= 1'b1;
      else if (gnt[1]) rr_ptr <= 1'b0;
      rvalid_q <= load_gnt;
      if (|load_gnt) rdata_q <= mem_q;
    end
  end

  // Reset masks the response so a load granted just before reset never
  // reports valid during the reset cycle.
  assign rvalid = reset ? 2'b00 : rvalid_q;
  assign rdata  = reset ? '0    : rdata_q;

endmodule
`default_nettype wire
